// File: rtl/tl_master_arb_if.sv
// Signal bundle between the two-requester TileLink arbiter and its surroundings:
// two requester A/D port pairs, the shared master A/D channel and status outputs.
interface tl_master_arb_if #(
   parameter int ADR_WIDTH = 32,
   parameter int BUS_SIZE  = 8
);
   localparam int DW = 8 * BUS_SIZE;

   logic                 r0_a_valid, r0_a_ready;
   logic [2:0]           r0_a_opcode;
   logic [3:0]           r0_a_size;
   logic                 r0_a_source;
   logic [ADR_WIDTH-1:0] r0_a_address;
   logic [BUS_SIZE-1:0]  r0_a_mask;
   logic [DW-1:0]        r0_a_data;

   logic                 r1_a_valid, r1_a_ready;
   logic [2:0]           r1_a_opcode;
   logic [3:0]           r1_a_size;
   logic                 r1_a_source;
   logic [ADR_WIDTH-1:0] r1_a_address;
   logic [BUS_SIZE-1:0]  r1_a_mask;
   logic [DW-1:0]        r1_a_data;

   logic                 r0_d_valid, r0_d_ready;
   logic [2:0]           r0_d_opcode;
   logic [3:0]           r0_d_size;
   logic                 r0_d_source, r0_d_denied, r0_d_corrupt;
   logic [DW-1:0]        r0_d_data;

   logic                 r1_d_valid, r1_d_ready;
   logic [2:0]           r1_d_opcode;
   logic [3:0]           r1_d_size;
   logic                 r1_d_source, r1_d_denied, r1_d_corrupt;
   logic [DW-1:0]        r1_d_data;

   logic                 tl_master_a_valid, tl_master_a_ready;
   logic [2:0]           tl_master_a_bits_opcode, tl_master_a_bits_param;
   logic [3:0]           tl_master_a_bits_size;
   logic [1:0]           tl_master_a_bits_source;
   logic [ADR_WIDTH-1:0] tl_master_a_bits_address;
   logic [BUS_SIZE-1:0]  tl_master_a_bits_mask;
   logic [DW-1:0]        tl_master_a_bits_data;
   logic                 tl_master_a_bits_corrupt;

   logic                 tl_master_d_valid, tl_master_d_ready;
   logic [2:0]           tl_master_d_bits_opcode;
   logic [1:0]           tl_master_d_bits_param;
   logic [3:0]           tl_master_d_bits_size;
   logic [1:0]           tl_master_d_bits_source, tl_master_d_bits_sink;
   logic                 tl_master_d_bits_denied, tl_master_d_bits_corrupt;
   logic [DW-1:0]        tl_master_d_bits_data;

   logic [1:0]           out0_cnt, out1_cnt;
   logic                 err;

   // Arbiter view
   modport master (
      input  r0_a_valid, r0_a_opcode, r0_a_size, r0_a_source, r0_a_address, r0_a_mask, r0_a_data,
      input  r1_a_valid, r1_a_opcode, r1_a_size, r1_a_source, r1_a_address, r1_a_mask, r1_a_data,
      output r0_a_ready, r1_a_ready,
      output r0_d_valid, r0_d_opcode, r0_d_size, r0_d_source, r0_d_denied, r0_d_data, r0_d_corrupt,
      output r1_d_valid, r1_d_opcode, r1_d_size, r1_d_source, r1_d_denied, r1_d_data, r1_d_corrupt,
      input  r0_d_ready, r1_d_ready,
      output tl_master_a_valid, tl_master_a_bits_opcode, tl_master_a_bits_param, tl_master_a_bits_size,
      output tl_master_a_bits_source, tl_master_a_bits_address, tl_master_a_bits_mask,
      output tl_master_a_bits_data, tl_master_a_bits_corrupt,
      input  tl_master_a_ready,
      input  tl_master_d_valid, tl_master_d_bits_opcode, tl_master_d_bits_param, tl_master_d_bits_size,
      input  tl_master_d_bits_source, tl_master_d_bits_sink, tl_master_d_bits_denied,
      input  tl_master_d_bits_data, tl_master_d_bits_corrupt,
      output tl_master_d_ready,
      output out0_cnt, out1_cnt, err
   );

   // Requester/slave view
   modport slave (
      output r0_a_valid, r0_a_opcode, r0_a_size, r0_a_source, r0_a_address, r0_a_mask, r0_a_data,
      output r1_a_valid, r1_a_opcode, r1_a_size, r1_a_source, r1_a_address, r1_a_mask, r1_a_data,
      input  r0_a_ready, r1_a_ready,
      input  r0_d_valid, r0_d_opcode, r0_d_size, r0_d_source, r0_d_denied, r0_d_data, r0_d_corrupt,
      input  r1_d_valid, r1_d_opcode, r1_d_size, r1_d_source, r1_d_denied, r1_d_data, r1_d_corrupt,
      output r0_d_ready, r1_d_ready,
      input  tl_master_a_valid, tl_master_a_bits_opcode, tl_master_a_bits_param, tl_master_a_bits_size,
      input  tl_master_a_bits_source, tl_master_a_bits_address, tl_master_a_bits_mask,
      input  tl_master_a_bits_data, tl_master_a_bits_corrupt,
      output tl_master_a_ready,
      output tl_master_d_valid, tl_master_d_bits_opcode, tl_master_d_bits_param, tl_master_d_bits_size,
      output tl_master_d_bits_source, tl_master_d_bits_sink, tl_master_d_bits_denied,
      output tl_master_d_bits_data, tl_master_d_bits_corrupt,
      input  tl_master_d_ready,
      input  out0_cnt, out1_cnt, err
   );
endinterface

// File: rtl/tl_master_arb.sv
// Two-requester TileLink-UL A-channel arbiter with round-robin grant, per-requester
// outstanding limits, source-bit D routing and a sticky protocol-error flag.
module tl_master_arb #(
   parameter int ADR_WIDTH = 32,
   parameter int BUS_SIZE  = 8,
   parameter int MAX_OUT   = 2
) (
   input  logic            clock,
   input  logic            reset,
   tl_master_arb_if.master bus
);
   localparam int             DW       = 8 * BUS_SIZE;
   localparam logic [1:0]     MAX_CNT  = 2'(MAX_OUT);
   localparam logic [3:0]     MAX_SIZE = 4'($clog2(BUS_SIZE));

   typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

   state_t     r_state, w_state_next;
   logic       r_g, w_g_next;
   logic       r_p, w_p_next;
   logic [1:0] r_cnt [2];
   logic [1:0] w_cnt_next [2];
   logic       r_err, w_err_next;

   logic                 w_a_valid   [2];
   logic [2:0]           w_a_opcode  [2];
   logic [3:0]           w_a_size    [2];
   logic                 w_a_source  [2];
   logic [ADR_WIDTH-1:0] w_a_address [2];
   logic [BUS_SIZE-1:0]  w_a_mask    [2];
   logic [DW-1:0]        w_a_data    [2];
   logic                 w_d_ready   [2];

   assign w_a_valid[0]   = bus.r0_a_valid;
   assign w_a_opcode[0]  = bus.r0_a_opcode;
   assign w_a_size[0]    = bus.r0_a_size;
   assign w_a_source[0]  = bus.r0_a_source;
   assign w_a_address[0] = bus.r0_a_address;
   assign w_a_mask[0]    = bus.r0_a_mask;
   assign w_a_data[0]    = bus.r0_a_data;
   assign w_d_ready[0]   = bus.r0_d_ready;
   assign w_a_valid[1]   = bus.r1_a_valid;
   assign w_a_opcode[1]  = bus.r1_a_opcode;
   assign w_a_size[1]    = bus.r1_a_size;
   assign w_a_source[1]  = bus.r1_a_source;
   assign w_a_address[1] = bus.r1_a_address;
   assign w_a_mask[1]    = bus.r1_a_mask;
   assign w_a_data[1]    = bus.r1_a_data;
   assign w_d_ready[1]   = bus.r1_d_ready;

   logic w_a_fire, w_d_dst, w_d_fire, w_bad_req;
   logic w_elig [2];
   logic w_inc [2];
   logic w_dec [2];
   logic w_underflow [2];

   assign w_a_fire = (r_state == ST_HOLD) && bus.tl_master_a_ready;
   assign w_d_dst  = bus.tl_master_d_bits_source[1];
   assign w_d_fire = bus.tl_master_d_valid && bus.tl_master_d_ready;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign w_elig[gi]      = w_a_valid[gi] && (r_cnt[gi] < MAX_CNT);
         assign w_inc[gi]       = w_a_fire && (r_g == 1'(gi));
         assign w_dec[gi]       = w_d_fire && (w_d_dst == 1'(gi));
         assign w_underflow[gi] = w_dec[gi] && (r_cnt[gi] == 2'd0);
         // A decrement at zero is discarded, so a concurrent increment still counts.
         assign w_cnt_next[gi]  = (w_inc[gi] && (!w_dec[gi] || w_underflow[gi])) ? r_cnt[gi] + 2'd1 :
                                  (w_dec[gi] && !w_inc[gi] && !w_underflow[gi])  ? r_cnt[gi] - 2'd1 :
                                                                                   r_cnt[gi];
      end
   endgenerate

   // Only Get, PutFull and PutPartial fit within one beat of this bus.
   assign w_bad_req = w_a_fire &&
                      (!(w_a_opcode[r_g] == 3'd0 || w_a_opcode[r_g] == 3'd1 || w_a_opcode[r_g] == 3'd4) ||
                       (w_a_size[r_g] > MAX_SIZE));
   assign w_err_next = r_err || w_bad_req || w_underflow[0] || w_underflow[1];

   always_comb begin
      w_state_next = r_state;
      w_g_next     = r_g;
      w_p_next     = r_p;
      case (r_state)
         ST_IDLE: begin
            if (w_elig[0] || w_elig[1]) begin
               w_state_next = ST_HOLD;
               w_g_next     = (w_elig[0] && w_elig[1]) ? r_p : w_elig[1];
            end
         end
         ST_HOLD: begin
            if (bus.tl_master_a_ready) begin
               w_state_next = ST_IDLE;
               w_p_next     = ~r_g;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_g      <= 1'b0;
         r_p      <= 1'b0;
         r_cnt[0] <= 2'd0;
         r_cnt[1] <= 2'd0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_g      <= w_g_next;
         r_p      <= w_p_next;
         r_cnt[0] <= w_cnt_next[0];
         r_cnt[1] <= w_cnt_next[1];
         r_err    <= w_err_next;
      end
   end

   // Payload is not registered: the granted requester holds it stable through HOLD.
   assign bus.tl_master_a_valid        = (r_state == ST_HOLD);
   assign bus.tl_master_a_bits_opcode  = w_a_opcode[r_g];
   assign bus.tl_master_a_bits_param   = 3'd0;
   assign bus.tl_master_a_bits_size    = w_a_size[r_g];
   assign bus.tl_master_a_bits_source  = {r_g, w_a_source[r_g]};
   assign bus.tl_master_a_bits_address = w_a_address[r_g];
   assign bus.tl_master_a_bits_mask    = w_a_mask[r_g];
   assign bus.tl_master_a_bits_data    = w_a_data[r_g];
   assign bus.tl_master_a_bits_corrupt = 1'b0;
   assign bus.r0_a_ready               = w_a_fire && !r_g;
   assign bus.r1_a_ready               = w_a_fire && r_g;

   assign bus.tl_master_d_ready = w_d_ready[w_d_dst];
   assign bus.r0_d_valid        = bus.tl_master_d_valid && !w_d_dst;
   assign bus.r0_d_opcode       = bus.tl_master_d_bits_opcode;
   assign bus.r0_d_size         = bus.tl_master_d_bits_size;
   assign bus.r0_d_source       = bus.tl_master_d_bits_source[0];
   assign bus.r0_d_denied       = bus.tl_master_d_bits_denied;
   assign bus.r0_d_data         = bus.tl_master_d_bits_data;
   assign bus.r0_d_corrupt      = bus.tl_master_d_bits_corrupt;
   assign bus.r1_d_valid        = bus.tl_master_d_valid && w_d_dst;
   assign bus.r1_d_opcode       = bus.tl_master_d_bits_opcode;
   assign bus.r1_d_size         = bus.tl_master_d_bits_size;
   assign bus.r1_d_source       = bus.tl_master_d_bits_source[0];
   assign bus.r1_d_denied       = bus.tl_master_d_bits_denied;
   assign bus.r1_d_data         = bus.tl_master_d_bits_data;
   assign bus.r1_d_corrupt      = bus.tl_master_d_bits_corrupt;

   assign bus.out0_cnt = r_cnt[0];
   assign bus.out1_cnt = r_cnt[1];
   assign bus.err      = r_err;
endmodule

// File: doc/tl_master_arb.md
TL_MASTER_ARB -- requirements
Module: tl_master_arb

Interface
REQ-001 Parameter ADR_WIDTH, default 32, address width of all A channels.
REQ-002 Parameter BUS_SIZE, default 8, data bytes per beat; data width is 8*BUS_SIZE, mask width is BUS_SIZE.
REQ-003 Parameter MAX_OUT, default 2, range 1..2, maximum outstanding requests per requester.
REQ-004 Port clock  input  1  single clock; all logic rising-edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Ports rN_a_valid input 1 / rN_a_ready output 1, for N=0,1: requester A handshake.
REQ-007 Ports rN_a_opcode input 3, rN_a_size input 4, rN_a_source input 1, rN_a_address input ADR_WIDTH, rN_a_mask input BUS_SIZE, rN_a_data input 8*BUS_SIZE: requester A fields.
REQ-008 Ports rN_d_valid output 1 / rN_d_ready input 1: requester D handshake.
REQ-009 Ports rN_d_opcode output 3, rN_d_size output 4, rN_d_source output 1, rN_d_denied output 1, rN_d_data output 8*BUS_SIZE, rN_d_corrupt output 1: requester D fields.
REQ-010 Ports tl_master_a_valid output 1, tl_master_a_ready input 1, tl_master_a_bits_opcode output 3, _param output 3, _size output 4, _source output 2, _address output ADR_WIDTH, _mask output BUS_SIZE, _data output 8*BUS_SIZE, _corrupt output 1: shared A channel.
REQ-011 Ports tl_master_d_valid input 1, tl_master_d_ready output 1, tl_master_d_bits_opcode input 3, _param input 2, _size input 4, _source input 2, _sink input 2, _denied input 1, _data input 8*BUS_SIZE, _corrupt input 1: shared D channel.
REQ-012 Ports outN_cnt output 2 (N=0,1): outstanding count per requester; err output 1: sticky protocol error.

Function
REQ-013 A-side FSM SHALL have states IDLE and HOLD, plus a registered grant index g and a round-robin pointer p.
REQ-014 In IDLE, eligible(N) = rN_a_valid && outN_cnt < MAX_OUT; if both eligible, grant p; else grant the single eligible one; none eligible -> stay IDLE.
REQ-015 On grant, the FSM SHALL register g and enter HOLD on the next edge; A latency from rN_a_valid to tl_master_a_valid is exactly 1 cycle.
REQ-016 In HOLD, tl_master_a_valid = 1 and A fields SHALL be driven combinationally from requester g; tl_master_a_bits_source = {g, rg_a_source}; param = 0; corrupt = 0.
REQ-017 rN_a_ready = (state==HOLD) && (g==N) && tl_master_a_ready; all other rN_a_ready = 0.
REQ-018 A fire (HOLD && tl_master_a_ready) SHALL return FSM to IDLE and set p = ~g; no back-to-back grant in the fire cycle (max one A beat per 2 cycles).
REQ-019 Requester g SHALL hold fields stable in HOLD; arbiter does not register payload.
REQ-020 D routing: rN_d_valid = tl_master_d_valid && (tl_master_d_bits_source[1]==N); rN_d_source = tl_master_d_bits_source[0]; other D fields broadcast to both requesters; param and sink dropped.
REQ-021 tl_master_d_ready = rN_d_ready of N = tl_master_d_bits_source[1]; purely combinational, zero latency.
REQ-022 outN_cnt increments on A fire for N, decrements on D fire for N; simultaneous increment and decrement leaves it unchanged.
REQ-023 D fire to requester with outN_cnt==0 SHALL set err and leave the counter at 0 (no wrap).
REQ-024 A grant with opcode not in {0,1,4} or size > log2(BUS_SIZE) SHALL set err at fire; the request is still forwarded.
REQ-025 err SHALL remain set until reset.

Reset
REQ-026 On reset high at a clock edge: state=IDLE, g=0, p=0, outN_cnt=0, err=0; tl_master_a_valid and all rN_a_ready SHALL be 0 the following cycle.
REQ-027 Reset asserted in HOLD SHALL abandon the pending grant without an A fire; counters clear regardless of outstanding D.

Verification
REQ-028 r0 Get (opcode 4, size 3, source 1, address 0x7000_0000), a_ready=1 -> tl_master_a_valid 1 cycle later, source=2'b01, fire, out0_cnt=1; D source 2'b01 -> r0_d_valid=1, r0_d_source=1, out0_cnt=0.
REQ-029 r0 and r1 valid continuously, a_ready=1, p=0 after reset -> grants alternate r0,r1,r0,r1 limited by MAX_OUT=2; third r0 request stalls until a D returns for r0.
REQ-030 a_ready held 0 for 5 cycles in HOLD -> tl_master_a_valid stays 1, fields stable, no grant change; a_ready=1 -> single fire.
REQ-031 Same-cycle A fire and D fire for r1 with out1_cnt=1 -> out1_cnt stays 1.
REQ-032 D valid with source 2'b10 and out1_cnt=0 -> r1_d_valid=1, err=1 next cycle, out1_cnt=0; opcode 7 request -> err=1, forwarded.
REQ-033 Reset during HOLD with out0_cnt=2 -> next cycle state IDLE, a_valid 0, out0_cnt=0, err=0.
